// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: widths,
// the x0 register, the write-enable level and the requester indices.
package wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
    localparam int NUM_WB_REQ     = 4;

    localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg     = '0;
    localparam logic                      WriteEnable = 1'b1;

    // Requester slots; index 0 is the highest fixed priority.
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;
    localparam int REQ_CSR = 3;

    // Width of a pointer that can name any of n requesters (never zero).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback request bundle between the execution units and the arbiter.
// Handshake: a requester raises req_valid_i[k] with its address/data and
// holds all three stable until the cycle in which req_ready_o[k] is also
// high; that cycle is the transfer. Dropping valid early is illegal.
// req_ready_o is one-hot or zero and never depends on address or data.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ
) ();

    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*REG_DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]                req_ready_o;

    modport master (
        output req_valid_i,
        output req_addr_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_addr_i,
        input  req_data_i,
        output req_ready_o
    );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational one-hot picker: the search starts at ptr_i and wraps,
// so a constant zero pointer gives plain lowest-index-wins priority.
module wb_rr_picker
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    int   idx;
    logic found;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid_i[idx[PTR_W-1:0]]) begin
                grant_o[idx[PTR_W-1:0]] = 1'b1;
                found                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Build option WB_ARB_RR_EN: when defined, priority rotates past each
// winner; when undefined, fixed priority with the lowest index winning.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ
) (
    input  logic                      clk,
    input  logic                      rst,
    wb_arbiter_if.slave               req_if,
    input  logic                      issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2_i,
    output logic                      rs1_busy_o,
    output logic                      rs2_busy_o,
    output logic [NUM_REGS-1:0]       busy_mask_o,
    output logic                      we_o,
    output logic [REG_ADDR_WIDTH-1:0] waddr_o,
    output logic [REG_DATA_WIDTH-1:0] wdata_o
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [NUM_REQ-1:0]        pick;
    logic [NUM_REQ-1:0]        grant;
    logic                      grant_any;
    logic [PTR_W-1:0]          ptr;
    logic [REG_ADDR_WIDTH-1:0] gnt_addr;
    logic [REG_DATA_WIDTH-1:0] gnt_data;

    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] grant_idx;

    // Encode the one-hot grant so the pointer can step past the winner.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                grant_idx = PTR_W'(k);
            end
        end
    end

    // Winner becomes lowest priority next time; hold when nothing granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Rotating-priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    wb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid_i (req_if.req_valid_i),
        .ptr_i   (ptr),
        .grant_o (pick)
    );

    // No grant while in reset, so nothing in flight survives it.
    assign grant              = rst ? '0 : pick;
    assign grant_any          = |grant;
    assign req_if.req_ready_o = grant;

    // Route the winner's address and data toward the write-port registers.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gnt_addr = req_if.req_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                gnt_data = req_if.req_data_i[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            end
        end
    end

    // Scoreboard and write-port next state; a new issue beats a same-address retire.
    always_comb begin
        busy_d  = busy_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_any) begin
            waddr_d = gnt_addr;
            wdata_d = gnt_data;
            if (gnt_addr != ZeroReg) begin
                we_d             = WriteEnable;
                busy_d[gnt_addr] = 1'b0;
            end
        end
        if (issue_valid_i && (issue_rd_i != ZeroReg)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write on we_o has already cleared its bit, so it reads as not busy
    // and the register file forwards the data.
    assign rs1_busy_o  = (raddr1_i != ZeroReg) && busy_q[raddr1_i];
    assign rs2_busy_o  = (raddr2_i != ZeroReg) && busy_q[raddr2_i];
    assign busy_mask_o = busy_q;
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: requester/decode driver with a reference model,
// expected-value queues and an independent monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NR    = NUM_WB_REQ;
  localparam int A     = REG_ADDR_WIDTH;
  localparam int D     = REG_DATA_WIDTH;
  localparam int NREGS = NUM_REGS;
  localparam int WR_W  = 1 + A + D + NREGS;
  localparam int CM_W  = NR + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             issue_valid;
  logic [A-1:0]     issue_rd, raddr1, raddr2;
  logic             rs1_busy, rs2_busy;
  logic [NREGS-1:0] busy_mask;
  logic             we;
  logic [A-1:0]     waddr;
  logic [D-1:0]     wdata;

  wb_arbiter_if #(.NUM_REQ(NR)) req_if ();

  wb_arbiter #(.NUM_REQ(NR)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_if        (req_if.slave),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .raddr1_i      (raddr1),
    .raddr2_i      (raddr2),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .busy_mask_o   (busy_mask),
    .we_o          (we),
    .waddr_o       (waddr),
    .wdata_o       (wdata)
  );

  // ---------------- reference model state ----------------
  bit           pend [NR];
  int           paddr[NR];
  logic [D-1:0] pdata[NR];
  int           m_ptr;
  bit           m_busy[NREGS];
  logic [A-1:0] m_waddr;
  logic [D-1:0] m_wdata;

  logic [WR_W-1:0] exp_wr_q[$];
  logic [CM_W-1:0] exp_comb_q[$];

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // A requester posts a write; it stays pending until the model grants it.
  task automatic post_req(input int k, input int addr, input logic [D-1:0] data);
    if (!pend[k]) begin
      pend[k]  = 1'b1;
      paddr[k] = addr;
      pdata[k] = data;
    end
  endtask

  // One clock cycle: drive inputs, predict responses, advance the model.
  task automatic step(input bit r, input bit iv, input int ird, input int ra1, input int ra2);
    int               w;
    int               k;
    logic [NR-1:0]    g;
    logic             rs1e, rs2e, wexp;
    logic [NREGS-1:0] bvec;
    @(negedge clk);
    #1;
    rst         = r;
    issue_valid = iv;
    issue_rd    = A'(ird);
    raddr1      = A'(ra1);
    raddr2      = A'(ra2);
    for (int j = 0; j < NR; j++) begin
      req_if.req_valid_i[j]         = pend[j];
      req_if.req_addr_i[j*A +: A]   = A'(paddr[j]);
      req_if.req_data_i[j*D +: D]   = pdata[j];
    end
    // Winner: first pending requester searching upward from the pointer.
    w = -1;
    g = '0;
    if (!r) begin
      for (int j = 0; j < NR; j++) begin
        k = (m_ptr + j) % NR;
        if (w < 0 && pend[k]) w = k;
      end
    end
    if (w >= 0) g[w] = 1'b1;
    rs1e = (ra1 != 0) && m_busy[ra1];
    rs2e = (ra2 != 0) && m_busy[ra2];
    exp_comb_q.push_back({g, rs1e, rs2e});
    if (r) begin
      m_ptr   = 0;
      for (int j = 0; j < NREGS; j++) m_busy[j] = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      wexp    = 1'b0;
    end else begin
      wexp = (w >= 0) && (paddr[w] != 0);
      if (w >= 0) begin
        if (paddr[w] != 0) m_busy[paddr[w]] = 1'b0;
        m_waddr = A'(paddr[w]);
        m_wdata = pdata[w];
        pend[w] = 1'b0;
`ifdef WB_ARB_RR_EN
        m_ptr = (w + 1) % NR;
`endif
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
    end
    for (int j = 0; j < NREGS; j++) bvec[j] = m_busy[j];
    exp_wr_q.push_back({wexp, m_waddr, m_wdata, bvec});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [WR_W-1:0]  e;
  logic [CM_W-1:0]  c;
  logic             e_we;
  logic [A-1:0]     e_waddr;
  logic [D-1:0]     e_wdata;
  logic [NREGS-1:0] e_busy;
  logic [NR-1:0]    c_rdy;
  logic             c_rs1, c_rs2;
  logic [NR-1:0]    prev_valid, prev_rdy;
  logic [NR*A-1:0]  prev_addr;
  logic [NR*D-1:0]  prev_data;
  logic             prev_rst;

  initial begin
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (exp_wr_q.size() > 0) begin
        e = exp_wr_q.pop_front();
        {e_we, e_waddr, e_wdata, e_busy} = e;
        chk("we_o", 64'(we), 64'(e_we));
        chk("waddr_o", 64'(waddr), 64'(e_waddr));
        chk("wdata_o", 64'(wdata), 64'(e_wdata));
        chk("busy_mask_o", 64'(busy_mask), 64'(e_busy));
      end
      #3;
      if (exp_comb_q.size() > 0) begin
        c = exp_comb_q.pop_front();
        {c_rdy, c_rs1, c_rs2} = c;
        chk("req_ready_o", 64'(req_if.req_ready_o), 64'(c_rdy));
        chk("rs1_busy_o", 64'(rs1_busy), 64'(c_rs1));
        chk("rs2_busy_o", 64'(rs2_busy), 64'(c_rs2));
        // A request not yet granted must still be presented unchanged.
        if (!rst && !prev_rst) begin
          for (int k = 0; k < NR; k++) begin
            if (prev_valid[k] && !prev_rdy[k]) begin
              chk("hold_valid", 64'(req_if.req_valid_i[k]), 64'(1));
              chk("hold_addr", 64'(req_if.req_addr_i[k*A +: A]), 64'(prev_addr[k*A +: A]));
            end
          end
        end
        prev_valid = req_if.req_valid_i;
        prev_rdy   = req_if.req_ready_o;
        prev_addr  = req_if.req_addr_i;
        prev_data  = req_if.req_data_i;
        prev_rst   = rst;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_rd = '0;
    raddr1 = '0;
    raddr2 = '0;
    req_if.req_valid_i = '0;
    req_if.req_addr_i  = '0;
    req_if.req_data_i  = '0;
    m_ptr = 0;
    m_waddr = '0;
    m_wdata = '0;
    for (int j = 0; j < NREGS; j++) m_busy[j] = 1'b0;
    for (int j = 0; j < NR; j++) begin
      pend[j] = 1'b0;
      paddr[j] = 0;
      pdata[j] = '0;
    end

    // Reset held three cycles with every requester valid, then contention.
    for (int j = 0; j < NR; j++) post_req(j, j + 1, $urandom());
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 2);

    // Single write from the LSU.
    post_req(REQ_LSU, 5, 32'hDEADBEEF);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);

    // Issue to x7, then the LSU retires it.
    step(0, 1, 7, 0, 0);
    step(0, 0, 0, 7, 7);
    post_req(REQ_LSU, 7, $urandom());
    step(0, 0, 0, 7, 0);
    step(0, 0, 0, 7, 0);

    // Issue and retire of x9 in the same cycle: the issue wins.
    post_req(REQ_ALU, 9, $urandom());
    step(0, 1, 9, 9, 0);
    step(0, 0, 0, 9, 0);

    // x0 as issue target and as write address.
    post_req(REQ_MDU, 0, $urandom());
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset in the middle of contention.
    for (int j = 0; j < NR; j++) post_req(j, 10 + j, $urandom());
    step(0, 1, 12, 12, 0);
    step(1, 1, 13, 0, 0);
    repeat (5) step(0, 0, 0, 12, 13);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0)
          post_req(k, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NREGS - 1), $urandom());
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
           $urandom_range(0, NREGS - 1));
    end

    // Let everything drain.
    repeat (8) step(0, 0, 0, 0, 0);
    @(negedge clk);
    #5;
    chk("queues_drained", 64'(exp_wr_q.size() + exp_comb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
